// File: rtl/apb_rr_master_pkg.sv
// Shared types for the round-robin APB master.
//   apb_mst_st_e : master FSM states
//   PH_*         : {psel, penable} encoding of each APB phase
package apb_rr_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_mst_st_e;

  // {psel, penable}
  localparam logic [1:0] PH_IDLE   = 2'b00;
  localparam logic [1:0] PH_SETUP  = 2'b10;
  localparam logic [1:0] PH_ACCESS = 2'b11;

endpackage

// File: rtl/apb_rr_master_if.sv
// Bus bundle for apb_rr_master: the client request/response side plus
// the APB master port.
//   master modport : view of the APB master (apb_rr_master itself)
//   slave  modport : view of everything around it (clients + APB slave)
// Per-client address/data are packed [client][bit], so client i sits at
// flat bits [i*W +: W].
interface apb_rr_master_if #(
  parameter int NUM_REQ   = 4,
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ-1:0]                req_write;
  logic [NUM_REQ-1:0][addrWidth-1:0] req_addr;
  logic [NUM_REQ-1:0][dataWidth-1:0] req_wdata;
  logic [NUM_REQ-1:0]                gnt;
  logic                              rsp_valid;
  logic [IW-1:0]                     rsp_id;
  logic [dataWidth-1:0]              rsp_rdata;
  logic                              rsp_err;
  logic [addrWidth-1:0]              paddr;
  logic                              pwrite;
  logic                              psel;
  logic                              penable;
  logic [dataWidth-1:0]              pwdata;
  logic [dataWidth-1:0]              prdata;
  logic                              pready;

  modport master (
    input  req, req_write, req_addr, req_wdata, prdata, pready,
    output gnt, rsp_valid, rsp_id, rsp_rdata, rsp_err,
           paddr, pwrite, psel, penable, pwdata
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, prdata, pready,
    input  gnt, rsp_valid, rsp_id, rsp_rdata, rsp_err,
           paddr, pwrite, psel, penable, pwdata
  );

endinterface

// File: rtl/apb_rr_master_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector
//   ptr_i : index of the previous winner; search starts at ptr_i+1
//   gnt_o : one-hot grant, idx_o : its index, any_o : some request set
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] lane;

  // Walk ptr+1 .. ptr+N (mod N); the first set bit wins, so the previous
  // winner is checked last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    lane  = '0;
    for (int i = 1; i <= N; i++) begin
      lane = IW'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[lane]) begin
        any_o       = 1'b1;
        idx_o       = lane;
        gnt_o[lane] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Multi-requester APB master: NUM_REQ clients share one APB slave.
// Round-robin arbitration in IDLE, then SETUP and ACCESS phases, then a
// registered response (data or timeout error) in the following cycle.
//   clk   : clock, posedge
//   rst_n : synchronous reset, active HIGH (rst_n=1 resets)
//   bus   : client request/response signals + APB master port
// gnt is the only combinational output (req -> gnt in IDLE); every APB
// output comes straight from a register.
module apb_rr_master #(
  parameter int NUM_REQ   = 4,
  parameter int addrWidth = 32,
  parameter int dataWidth = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  apb_rr_master_if.master   bus
);
  import apb_rr_master_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  apb_mst_st_e          state_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        id_q;
  logic [addrWidth-1:0] addr_q;
  logic                 write_q;
  logic [dataWidth-1:0] wdata_q;
  logic [WW-1:0]        wdog_q;
  logic                 psel_q;
  logic                 penable_q;
  logic                 rsp_valid_q;
  logic [IW-1:0]        rsp_id_q;
  logic [dataWidth-1:0] rsp_rdata_q;
  logic                 rsp_err_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Suppressed while reset is held so a client never sees a grant for a
  // request that the reset edge throws away.
  assign bus.gnt       = (state_q == ST_IDLE && !rst_n) ? arb_gnt : '0;
  assign bus.paddr     = addr_q;
  assign bus.pwrite    = write_q;
  assign bus.pwdata    = wdata_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q               <= ST_IDLE;
      ptr_q                 <= IW'(NUM_REQ - 1);  // client 0 wins first
      id_q                  <= '0;
      addr_q                <= '0;
      write_q               <= 1'b0;
      wdata_q               <= '0;
      wdog_q                <= '0;
      {psel_q, penable_q}   <= PH_IDLE;
      rsp_valid_q           <= 1'b0;
      rsp_id_q              <= '0;
      rsp_rdata_q           <= '0;
      rsp_err_q             <= 1'b0;
    end else begin
      // Response is a one-cycle pulse; fields read as 0 when not valid.
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            ptr_q               <= arb_idx;
            id_q                <= arb_idx;
            addr_q              <= bus.req_addr[arb_idx];
            write_q             <= bus.req_write[arb_idx];
            // pwdata is driven straight from this latch, so zero it on reads.
            wdata_q             <= bus.req_write[arb_idx] ? bus.req_wdata[arb_idx] : '0;
            {psel_q, penable_q} <= PH_SETUP;
            state_q             <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          {psel_q, penable_q} <= PH_ACCESS;
          state_q             <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.pready) begin
            rsp_valid_q         <= 1'b1;
            rsp_id_q            <= id_q;
            rsp_rdata_q         <= write_q ? '0 : bus.prdata;
            wdog_q              <= '0;
            {psel_q, penable_q} <= PH_IDLE;
            state_q             <= ST_IDLE;
          end else if (wdog_q == WW'(TIMEOUT - 1)) begin
            // TIMEOUT-th stalled ACCESS cycle: abort with an error response.
            rsp_valid_q         <= 1'b1;
            rsp_id_q            <= id_q;
            rsp_err_q           <= 1'b1;
            wdog_q              <= '0;
            {psel_q, penable_q} <= PH_IDLE;
            state_q             <= ST_IDLE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: begin
          {psel_q, penable_q} <= PH_IDLE;
          state_q             <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
module tb_apb_rr_master;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apb_rr_master_if #(.NUM_REQ(NR), .addrWidth(AW), .dataWidth(DW)) bus ();

  apb_rr_master #(.NUM_REQ(NR), .addrWidth(AW), .dataWidth(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // 32-word memory slave; pready held low for the first stall_cfg ACCESS cycles.
  logic [DW-1:0] mem [32];
  int            stall_cfg;
  int            acc_cnt;
  assign bus.pready = (acc_cnt >= stall_cfg);
  assign bus.prdata = mem[bus.paddr[4:0]];
  always @(posedge clk) begin
    if (bus.psel && bus.penable) begin
      acc_cnt <= acc_cnt + 1;
      if (bus.pready && bus.pwrite) mem[bus.paddr[4:0]] <= bus.pwdata;
    end else begin
      acc_cnt <= 0;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          client;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic [3:0]  exp_gnt;
    int          exp_acc;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  // Entered just after a posedge with the DUT in IDLE; returns at the
  // negedge of the response cycle.
  task automatic run_vec(input vec_t v, input int n);
    int          acc;
    logic [31:0] exp_wd;
    exp_wd = v.wr ? v.wdata : 32'h0;
    stall_cfg = v.stall;
    bus.req = '0;
    bus.req[v.client]       = 1'b1;
    bus.req_write[v.client] = v.wr;
    bus.req_addr[v.client]  = v.addr;
    bus.req_wdata[v.client] = v.wdata;
    @(negedge clk);
    chk($sformatf("v%0d gnt", n), bus.gnt, v.exp_gnt);
    chk($sformatf("v%0d idle_psel", n), bus.psel, 0);
    @(posedge clk); #1;
    bus.req = '0;
    @(negedge clk);
    chk($sformatf("v%0d setup_ph", n), {bus.psel, bus.penable}, 2'b10);
    chk($sformatf("v%0d setup_paddr", n), bus.paddr, v.addr);
    chk($sformatf("v%0d setup_pwdata", n), bus.pwdata, exp_wd);
    chk($sformatf("v%0d setup_pwrite", n), bus.pwrite, v.wr);
    acc = 0;
    forever begin
      @(negedge clk);
      if (!(bus.psel && bus.penable) || acc > 40) break;
      acc++;
      chk($sformatf("v%0d acc_paddr", n), bus.paddr, v.addr);
      chk($sformatf("v%0d acc_pwdata", n), bus.pwdata, exp_wd);
      chk($sformatf("v%0d acc_rsp_early", n), bus.rsp_valid, 0);
    end
    chk($sformatf("v%0d access_cycles", n), acc, v.exp_acc);
    chk($sformatf("v%0d rsp_psel", n), bus.psel, 0);
    chk($sformatf("v%0d rsp_valid", n), bus.rsp_valid, 1);
    chk($sformatf("v%0d rsp_id", n), bus.rsp_id, v.client);
    chk($sformatf("v%0d rsp_rdata", n), bus.rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d rsp_err", n), bus.rsp_err, v.exp_err);
    @(negedge clk);
    chk($sformatf("v%0d rsp_pulse", n), {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    //            client wr    addr      wdata         stall gnt      acc exp_rdata     err
    vecs[0] = '{2, 1'b1, 32'd5,    32'hDEADBEEF, 0,   4'b0100, 1,  32'h0,        1'b0};
    vecs[1] = '{1, 1'b0, 32'd5,    32'h0,        0,   4'b0010, 1,  32'hDEADBEEF, 1'b0};
    vecs[2] = '{3, 1'b1, 32'h21,   32'h12345678, 3,   4'b1000, 4,  32'h0,        1'b0};
    vecs[3] = '{0, 1'b0, 32'd1,    32'h0,        0,   4'b0001, 1,  32'h12345678, 1'b0};
    vecs[4] = '{2, 1'b0, 32'h25,   32'h0,        1,   4'b0100, 2,  32'hDEADBEEF, 1'b0};
    vecs[5] = '{3, 1'b0, 32'd2,    32'h0,        100, 4'b1000, 16, 32'h0,        1'b1};
    vecs[6] = '{1, 1'b1, 32'd31,   32'hA5A5A5A5, 0,   4'b0010, 1,  32'h0,        1'b0};
    vecs[7] = '{0, 1'b0, 32'd31,   32'h0,        0,   4'b0001, 1,  32'hA5A5A5A5, 1'b0};

    stall_cfg     = 0;
    rst_n         = 1'b1;
    bus.req       = 4'b1111;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset state, with every client already requesting.
    repeat (2) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_phase", {bus.psel, bus.penable}, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 0);

    // All requests held: grants 0,1,2,3,0 every 3 cycles, one IDLE cycle between.
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int k = 0; k < 15; k++) begin
      logic [3:0] eg;
      eg = (k % 3 == 0) ? 4'(1 << ((k / 3) % 4)) : 4'b0;
      @(negedge clk);
      chk($sformatf("rr_gnt k%0d", k), bus.gnt, eg);
      chk($sformatf("rr_psel k%0d", k), bus.psel, (k % 3) != 0);
      if (k >= 3 && k % 3 == 0) chk($sformatf("rr_rsp_id k%0d", k), bus.rsp_id, (k / 3) - 1);
    end
    bus.req = '0;
    @(negedge clk);
    chk("rr_last_rsp", {bus.rsp_valid, bus.rsp_id}, {1'b1, 2'd0});
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset during ACCESS: bus drops, no response, pointer back to client 0.
    stall_cfg = 10;
    bus.req[1] = 1'b1;
    bus.req_write[1] = 1'b0;
    bus.req_addr[1] = 32'd5;
    @(negedge clk);
    chk("mr_gnt", bus.gnt, 4'b0010);
    @(posedge clk); #1;
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("mr_in_access", {bus.psel, bus.penable}, 2'b11);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    chk("mr_phase", {bus.psel, bus.penable}, 0);
    chk("mr_no_rsp", bus.rsp_valid, 0);
    chk("mr_gnt_in_rst", bus.gnt, 0);
    stall_cfg = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_next_gnt", bus.gnt, 4'b0001);
    chk("mr_no_rsp2", bus.rsp_valid, 0);
    @(posedge clk); #1;
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk("mr_final_rsp", {bus.rsp_valid, bus.rsp_id}, {1'b1, 2'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
